ysyx_22051013_wb_arbiter: RTL and testbench
===========================================

YSYX_22051013_WB_ARBITER -- requirements
Module: ysyx_22051013_wb_arbiter

Interface
REQ-001 Parameter XLEN, 64, register data width.
REQ-002 Parameter CNT_W, 16, width of the conflict performance counter.
REQ-003 clk  input  1  sole clock; all state updates on posedge.
REQ-004 rst  input  1  reset, asynchronous, active-low (0 = reset).
REQ-005 req_valid  input  3  writeback request; bit0 EXU, bit1 LSU, bit2 MDU.
REQ-006 req_ready  output  3  one-hot grant; transfer when req_valid[i] and req_ready[i] are both 1.
REQ-007 req_addr  input  15  destination register per requester, 5 bits each, requester i at [5i+4:5i].
REQ-008 req_data  input  3*XLEN  writeback data per requester, requester i at [XLEN*i+XLEN-1:XLEN*i].
REQ-009 issue_en  input  1  an instruction with a destination register is issued this cycle.
REQ-010 issue_addr  input  5  destination register of the issued instruction.
REQ-011 flush  input  1  pipeline flush; clears scoreboard and arbitration state.
REQ-012 rf_wen  output  1  register-file write enable, registered.
REQ-013 rf_waddr  output  5  register-file write address, registered.
REQ-014 rf_wdata  output  XLEN  register-file write data, registered.
REQ-015 sb_busy  output  32  scoreboard; bit n = 1 means register n has a pending write.
REQ-016 perf_conflict  output  CNT_W  saturating count of cycles with 2 or more requests valid.

Function
REQ-017 Arbitration is round-robin over 3 requesters, using a 2-bit pointer rr_ptr (legal values 0..2); search order is rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3).
REQ-018 req_ready is combinational from req_valid and rr_ptr: at most one bit is set, only for a valid requester, and all bits are 0 when no request is valid.
REQ-019 After a transfer by requester g, rr_ptr becomes (g+1) mod 3; without a transfer rr_ptr holds its value.
REQ-020 A requester holds valid, addr and data stable until it is granted; the block never drops a granted transfer.
REQ-021 Latency: a transfer in cycle N gives rf_wen=1, rf_waddr=req_addr[g] and rf_wdata=req_data[g] in cycle N+1, for exactly one cycle.
REQ-022 A transfer with addr 0 is accepted (ready=1) but gives rf_wen=0 in N+1; rf_waddr/rf_wdata still update.
REQ-023 With no transfer, rf_wen=0 in the next cycle and rf_waddr/rf_wdata hold their previous values.
REQ-024 Scoreboard set: issue_en=1 with issue_addr!=0 sets sb_busy[issue_addr] at the next edge.
REQ-025 Scoreboard clear: a transfer with addr!=0 clears sb_busy[addr] at the same edge that registers the write.
REQ-026 If set and clear target the same register in the same cycle, set wins (newer producer).
REQ-027 sb_busy[0] is constant 0.
REQ-028 flush=1: at the next edge all sb_busy bits clear and rr_ptr becomes 0; issue_en in that same cycle is still applied after the clear.
REQ-029 flush does not block a transfer in the same cycle; that transfer still produces its rf_wen pulse.
REQ-030 perf_conflict increments by 1 at each edge where popcount(req_valid) >= 2, stays at 2^CNT_W-1 once reached, and is not affected by flush.
REQ-031 Every output is a registered value or a pure function of registered state and the current inputs; no output has a combinational path from rf_* to req_ready.

Reset
REQ-032 rst=0 asynchronously forces rf_wen=0, rf_waddr=0, rf_wdata=0, sb_busy=0, rr_ptr=0 and perf_conflict=0, and holds req_ready=0 while rst=0.
REQ-033 Reset asserted mid-transfer discards the registered write; after release, operation restarts from rr_ptr=0 with no spurious rf_wen.

Verification
REQ-034 Single request: LSU valid, addr 5, data 0xDEAD; expect req_ready=3'b010 in N, then rf_wen=1, waddr=5, wdata=0xDEAD in N+1 and rf_wen=0 in N+2.
REQ-035 Fairness: all three valid for 6 cycles starting from rr_ptr=0; expect grant order EXU, LSU, MDU, EXU, LSU, MDU and perf_conflict increasing by 6.
REQ-036 Scoreboard: issue addr 7 -> sb_busy[7]=1; MDU writes addr 7 while issue_addr=7 is issued in the same cycle -> sb_busy[7] stays 1.
REQ-037 x0 handling: issue_addr=0 leaves sb_busy=0; an EXU transfer to addr 0 gives ready=1 and rf_wen=0 in the next cycle.
REQ-038 Flush/reset: set busy on regs 3 and 9, then flush with issue_addr=4 -> sb_busy=0x10; assert rst=0 asynchronously mid-cycle -> all outputs 0 immediately.
REQ-039 Saturation: with CNT_W=4, hold 2 or more requests valid for 20 cycles; expect perf_conflict=15.

Source files
------------

// File: rtl/ysyx_22051013_wb_arbiter.sv
// Writeback arbiter: round-robin grant among EXU/LSU/MDU, registered
// register-file write port, destination-register scoreboard and a
// saturating counter of cycles with competing writeback requests.
module ysyx_22051013_wb_arbiter #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2:0]          req_valid,
    output logic [2:0]          req_ready,
    input  logic [14:0]         req_addr,
    input  logic [3*XLEN-1:0]   req_data,
    input  logic                issue_en,
    input  logic [4:0]          issue_addr,
    input  logic                flush,
    output logic                rf_wen,
    output logic [4:0]          rf_waddr,
    output logic [XLEN-1:0]     rf_wdata,
    output logic [31:0]         sb_busy,
    output logic [CNT_W-1:0]    perf_conflict
);

    // Round-robin pointer: the requester searched first in the next cycle.
    typedef enum logic [1:0] {
        PTR_EXU = 2'd0,
        PTR_LSU = 2'd1,
        PTR_MDU = 2'd2
    } rr_ptr_t;

    rr_ptr_t         rr_ptr, rr_ptr_next;
    logic [2:0]      valid_rot;
    logic [1:0]      grant_off;
    logic [2:0]      grant_sum;
    logic [1:0]      grant_idx;
    logic            grant_found;
    logic            transfer;
    logic [4:0]      sel_addr;
    logic [XLEN-1:0] sel_data;
    logic            conflict;
    logic [31:0]     sb_next;

    // Grant selection: rotate the valid vector so bit 0 is the pointer's requester.
    // NOTE: every combinational output gets a default first so no path leaves it unassigned, which would infer a latch.
    always_comb begin
        valid_rot   = req_valid;
        grant_off   = 2'd0;
        grant_found = 1'b0;
        case (rr_ptr)
            PTR_LSU: valid_rot = {req_valid[0], req_valid[2], req_valid[1]};
            PTR_MDU: valid_rot = {req_valid[1], req_valid[0], req_valid[2]};
            default: valid_rot = req_valid;
        endcase
        if (valid_rot[0]) begin
            grant_found = 1'b1;
            grant_off   = 2'd0;
        end else if (valid_rot[1]) begin
            grant_found = 1'b1;
            grant_off   = 2'd1;
        end else if (valid_rot[2]) begin
            grant_found = 1'b1;
            grant_off   = 2'd2;
        end
        grant_sum = {1'b0, rr_ptr} + {1'b0, grant_off};
        grant_idx = (grant_sum >= 3'd3) ? 2'(grant_sum - 3'd3) : grant_sum[1:0];
    end

    // One-hot ready, forced low while reset is asserted.
    always_comb begin
        req_ready = 3'b000;
        if (grant_found && rst) begin
            req_ready = 3'b001 << grant_idx;
        end
    end

    assign transfer = |(req_valid & req_ready);
    assign conflict = (req_valid[0] & req_valid[1]) |
                      (req_valid[0] & req_valid[2]) |
                      (req_valid[1] & req_valid[2]);

    // Mux the granted requester's destination and data.
    always_comb begin
        sel_addr = req_addr[4:0];
        sel_data = req_data[XLEN-1:0];
        case (grant_idx)
            2'd1: begin
                sel_addr = req_addr[9:5];
                sel_data = req_data[2*XLEN-1:XLEN];
            end
            2'd2: begin
                sel_addr = req_addr[14:10];
                sel_data = req_data[3*XLEN-1:2*XLEN];
            end
            default: begin
                sel_addr = req_addr[4:0];
                sel_data = req_data[XLEN-1:0];
            end
        endcase
    end

    // Next pointer: follows the granted requester, restarts at EXU on flush.
    always_comb begin
        rr_ptr_next = rr_ptr;
        if (transfer) begin
            case (grant_idx)
                2'd0:    rr_ptr_next = PTR_LSU;
                2'd1:    rr_ptr_next = PTR_MDU;
                default: rr_ptr_next = PTR_EXU;
            endcase
        end
        if (flush) begin
            rr_ptr_next = PTR_EXU;
        end
    end

    // Pointer state register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr <= PTR_EXU;
        end else begin
            rr_ptr <= rr_ptr_next;
        end
    end

    // Scoreboard update: flush clears, writeback clears, issue sets last so it wins.
    always_comb begin
        sb_next = flush ? 32'd0 : sb_busy;
        if (transfer && (sel_addr != 5'd0)) begin
            sb_next[sel_addr] = 1'b0;
        end
        if (issue_en && (issue_addr != 5'd0)) begin
            sb_next[issue_addr] = 1'b1;
        end
        sb_next[0] = 1'b0;
    end

    // Registered writeback port, scoreboard and conflict counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_wen        <= 1'b0;
            rf_waddr      <= 5'd0;
            rf_wdata      <= '0;
            sb_busy       <= 32'd0;
            perf_conflict <= '0;
        end else begin
            rf_wen  <= transfer && (sel_addr != 5'd0);
            if (transfer) begin
                rf_waddr <= sel_addr;
                rf_wdata <= sel_data;
            end
            sb_busy <= sb_next;
            if (conflict && (perf_conflict != {CNT_W{1'b1}})) begin
                perf_conflict <= perf_conflict + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_22051013_wb_arbiter.sv
// Bench for the writeback arbiter: directed scenarios followed by a random
// phase, all compared against a behavioural model of the arbitration rules.
module tb_ysyx_22051013_wb_arbiter;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic [2:0]      req_valid;
    logic [14:0]     req_addr;
    logic [3*XLEN-1:0] req_data;
    logic            issue_en;
    logic [4:0]      issue_addr;
    logic            flush;
    logic [2:0]      req_ready;
    logic            rf_wen;
    logic [4:0]      rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    logic [31:0]     sb_busy;
    logic [15:0]     perf_conflict;

    logic [2:0]      s_ready;
    logic            s_wen;
    logic [4:0]      s_waddr;
    logic [XLEN-1:0] s_wdata;
    logic [31:0]     s_busy;
    logic [3:0]      s_perf;

    always #5 clk = ~clk;

    ysyx_22051013_wb_arbiter #(.XLEN(XLEN), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data), .issue_en(issue_en),
        .issue_addr(issue_addr), .flush(flush), .rf_wen(rf_wen),
        .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .sb_busy(sb_busy),
        .perf_conflict(perf_conflict)
    );

    // Narrow-counter instance sharing the same stimulus, for saturation.
    ysyx_22051013_wb_arbiter #(.XLEN(XLEN), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(s_ready),
        .req_addr(req_addr), .req_data(req_data), .issue_en(issue_en),
        .issue_addr(issue_addr), .flush(flush), .rf_wen(s_wen),
        .rf_waddr(s_waddr), .rf_wdata(s_wdata), .sb_busy(s_busy),
        .perf_conflict(s_perf)
    );

    int errors = 0;
    int checks = 0;

    // Behavioural model state.
    int              m_ptr;
    logic [31:0]     m_busy;
    logic            m_wen;
    logic [4:0]      m_waddr;
    logic [XLEN-1:0] m_wdata;
    int              m_perf16;
    int              m_perf4;
    int              last_grant;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_busy = 0; m_wen = 0; m_waddr = 0; m_wdata = 0;
        m_perf16 = 0; m_perf4 = 0;
    endtask

    function automatic int model_grant();
        for (int k = 0; k < 3; k++) begin
            int i;
            i = (m_ptr + k) % 3;
            if (req_valid[i]) return i;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input logic [4:0] a, input logic [63:0] d);
        req_valid[i]          = 1'b1;
        req_addr[5*i +: 5]    = a;
        req_data[XLEN*i +: XLEN] = d;
    endtask

    // One clock cycle: check the grant before the edge, advance the model, check registers after.
    task automatic step(input string tag);
        int g;
        logic [63:0] exp_ready;
        logic [4:0]  ga;
        #1;
        g = model_grant();
        exp_ready = (g < 0) ? 64'd0 : (64'd1 << g);
        check({tag, "/ready"}, 64'(req_ready), exp_ready);
        last_grant = g;
        @(posedge clk);
        #1;
        if ($countones(req_valid) >= 2) begin
            if (m_perf16 < 65535) m_perf16++;
            if (m_perf4 < 15) m_perf4++;
        end
        if (g >= 0) begin
            ga      = req_addr[5*g +: 5];
            m_wen   = (ga != 5'd0);
            m_waddr = ga;
            m_wdata = req_data[XLEN*g +: XLEN];
            m_ptr   = (g + 1) % 3;
            if (ga != 5'd0) m_busy[ga] = 1'b0;
        end else begin
            m_wen = 1'b0;
        end
        if (flush) begin
            m_ptr  = 0;
            m_busy = 0;
        end
        if (issue_en && issue_addr != 5'd0) m_busy[issue_addr] = 1'b1;
        check({tag, "/wen"},   64'(rf_wen),        64'(m_wen));
        check({tag, "/waddr"}, 64'(rf_waddr),      64'(m_waddr));
        check({tag, "/wdata"}, rf_wdata,           m_wdata);
        check({tag, "/busy"},  64'(sb_busy),       64'(m_busy));
        check({tag, "/perf"},  64'(perf_conflict), 64'(m_perf16));
        check({tag, "/perf4"}, 64'(s_perf),        64'(m_perf4));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "/ready"}, 64'(req_ready),     64'd0);
        check({tag, "/wen"},   64'(rf_wen),        64'd0);
        check({tag, "/waddr"}, 64'(rf_waddr),      64'd0);
        check({tag, "/wdata"}, rf_wdata,           64'd0);
        check({tag, "/busy"},  64'(sb_busy),       64'd0);
        check({tag, "/perf"},  64'(perf_conflict), 64'd0);
        check({tag, "/perf4"}, 64'(s_perf),        64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int p0;
        rst = 1'b0; req_valid = 3'b111; req_addr = '0; req_data = '0;
        issue_en = 1'b0; issue_addr = 5'd0; flush = 1'b0;
        model_reset();

        // Reset state, with requests present.
        #2;
        check_all_zero("reset");
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset_held");
        rst = 1'b1; req_valid = 3'b000;

        // Single LSU request.
        set_req(1, 5'd5, 64'hDEAD);
        #1;
        check("single/ready_const", 64'(req_ready), 64'b010);
        step("single");
        check("single/wen_const",   64'(rf_wen),   64'd1);
        check("single/waddr_const", 64'(rf_waddr), 64'd5);
        check("single/wdata_const", rf_wdata,      64'hDEAD);
        req_valid = 3'b000;
        step("single_after");
        check("single/wen_off", 64'(rf_wen), 64'd0);

        // Fairness from pointer 0.
        flush = 1'b1;
        step("fair_flush");
        flush = 1'b0;
        set_req(0, 5'd1, 64'h11);
        set_req(1, 5'd2, 64'h22);
        set_req(2, 5'd3, 64'h33);
        p0 = m_perf16;
        for (int k = 0; k < 6; k++) begin
            #1;
            check("fair/order", 64'(req_ready), 64'd1 << (k % 3));
            step("fair");
        end
        check("fair/perf_delta", 64'(perf_conflict), 64'(p0 + 6));
        req_valid = 3'b000;

        // Scoreboard set beats a same-cycle clear.
        issue_en = 1'b1; issue_addr = 5'd7;
        step("sb_set");
        check("sb_set/bit7", 64'(sb_busy[7]), 64'd1);
        set_req(2, 5'd7, 64'h7777);
        step("sb_race");
        check("sb_race/bit7", 64'(sb_busy[7]), 64'd1);
        req_valid = 3'b000; issue_en = 1'b0;

        // x0 handling.
        flush = 1'b1;
        step("x0_flush");
        flush = 1'b0;
        issue_en = 1'b1; issue_addr = 5'd0;
        step("x0_issue");
        check("x0_issue/busy", 64'(sb_busy), 64'd0);
        issue_en = 1'b0;
        set_req(0, 5'd0, 64'hABCD);
        #1;
        check("x0_xfer/ready_const", 64'(req_ready), 64'b001);
        step("x0_xfer");
        check("x0_xfer/wen_const", 64'(rf_wen), 64'd0);
        req_valid = 3'b000;

        // Flush with same-cycle issue.
        issue_en = 1'b1; issue_addr = 5'd3;
        step("fl_i3");
        issue_addr = 5'd9;
        step("fl_i9");
        flush = 1'b1; issue_addr = 5'd4;
        step("fl_flush");
        check("fl_flush/busy_const", 64'(sb_busy), 64'h10);
        flush = 1'b0; issue_en = 1'b0;

        // Asynchronous reset mid-cycle during a pending transfer.
        set_req(0, 5'd12, 64'h1234);
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(posedge clk);
        #1;
        check_all_zero("async_rst_edge");
        model_reset();
        rst = 1'b1; req_valid = 3'b000;
        step("post_rst");

        // Saturation of the narrow counter.
        set_req(0, 5'd1, 64'h1);
        set_req(1, 5'd2, 64'h2);
        set_req(2, 5'd3, 64'h3);
        for (int k = 0; k < 20; k++) step("sat");
        check("sat/perf4_const",  64'(s_perf),        64'd15);
        check("sat/perf16_const", 64'(perf_conflict), 64'd20);
        req_valid = 3'b000;

        // Random traffic; requesters hold their request until granted.
        for (int n = 0; n < 400; n++) begin
            issue_en   = ($urandom_range(0, 1) == 1);
            issue_addr = 5'($urandom_range(0, 31));
            flush      = ($urandom_range(0, 15) == 0);
            for (int i = 0; i < 3; i++) begin
                if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
                    set_req(i, 5'($urandom_range(0, 31)), {$urandom, $urandom});
                end
            end
            step("rand");
            if (last_grant >= 0) req_valid[last_grant] = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
